// File: rtl/deinterleaver_if.sv
// deinterleaver_if: bit-serial handshake bundle between demapper, deinterleaver and decoder.
// slave = deinterleaver side, master = the surrounding demapper/decoder side.
// Macro DEINTERLEAVER_LAST_EN adds the last_deinterleaver / block_count signals.
interface deinterleaver_if #(
    parameter int NCBPS = 192
);
    localparam int IDX_W = $clog2(NCBPS);

    logic             valid_demapper;
    logic             data_in;
    logic             ready_deinterleaver;
    logic             ready_decoder;
    logic             data_out;
    logic [IDX_W-1:0] data_out_index;
    logic             valid_deinterleaver;
`ifdef DEINTERLEAVER_LAST_EN
    logic             last_deinterleaver;
    logic [15:0]      block_count;
`endif

    modport slave (
        input  valid_demapper, data_in, ready_decoder,
        output ready_deinterleaver, data_out, data_out_index, valid_deinterleaver
`ifdef DEINTERLEAVER_LAST_EN
        , output last_deinterleaver, block_count
`endif
    );

    modport master (
        output valid_demapper, data_in, ready_decoder,
        input  ready_deinterleaver, data_out, data_out_index, valid_deinterleaver
`ifdef DEINTERLEAVER_LAST_EN
        , input last_deinterleaver, block_count
`endif
    );
endinterface

// File: rtl/deinterleaver.sv
// deinterleaver: WiMAX QPSK block de-interleaver, ping-pong banks, 1 bit/cycle in and out.
// Latency: first output bit of a block is valid the cycle after its last input bit is accepted.
// Backpressure: ready_deinterleaver drops while the write bank is still full; outputs hold while ready_decoder=0.
// Optional macro DEINTERLEAVER_LAST_EN adds last_deinterleaver and a 16-bit block_count.
module deinterleaver #(
    parameter int NCBPS = 192,
    parameter int NCPC  = 2,
    parameter int D     = 16
) (
    input  logic           clk,
    input  logic           resetN,
    deinterleaver_if.slave bus
);
    localparam int R      = NCBPS / D;
    localparam int ADDR_W = $clog2(NCBPS);
    localparam int COL_W  = (R > 1) ? $clog2(R) : 1;
    localparam int ROW_W  = (D > 1) ? $clog2(D) : 1;

    generate
        if (NCPC != 2) begin : g_bad_ncpc
            $error("deinterleaver: only NCPC=2 (QPSK) is supported");
        end
        if ((NCBPS % D) != 0) begin : g_bad_d
            $error("deinterleaver: NCBPS must be divisible by D");
        end
    endgenerate

    // Two block buffers; contents are deliberately not reset.
    logic [NCBPS-1:0]  r_bank [2];
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [1:0]        r_full;
    logic [1:0]        w_full_nxt;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [ADDR_W-1:0] r_rd_cnt;

    logic              w_ready;
    logic              w_valid;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_col_last;
    logic              w_wr_last;
    logic              w_rd_last;
    logic [ADDR_W-1:0] w_wr_addr;

    assign w_ready    = ~r_full[r_wr_bank];
    assign w_valid    = r_full[r_rd_bank];
    assign w_wr_fire  = bus.valid_demapper & w_ready;
    assign w_rd_fire  = w_valid & bus.ready_decoder;
    assign w_col_last = (r_col == COL_W'(R - 1));
    assign w_wr_last  = w_wr_fire & w_col_last & (r_row == ROW_W'(D - 1));
    assign w_rd_last  = w_rd_fire & (r_rd_cnt == ADDR_W'(NCBPS - 1));

    // k = row + D*col; D is a constant so this reduces to shift/add.
    assign w_wr_addr  = ADDR_W'(r_row) + ADDR_W'(r_col) * ADDR_W'(D);

    assign bus.ready_deinterleaver = w_ready;
    assign bus.valid_deinterleaver = w_valid;
    assign bus.data_out            = w_valid ? r_bank[r_rd_bank][r_rd_cnt] : 1'b0;
    assign bus.data_out_index      = r_rd_cnt;

    // Full flags: a fill and a drain of opposite banks may land in the same cycle.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    // Store accepted bits at their de-interleaved position in the write bank.
    always_ff @(posedge clk) begin
        if (w_wr_fire && !resetN) begin
            r_bank[r_wr_bank][w_wr_addr] <= bus.data_in;
        end
    end

    // Write-side counters: col runs fastest, row advances on col wrap, bank flips at block end.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            r_col     <= '0;
            r_row     <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_wr_fire) begin
            if (w_wr_last) begin
                r_col     <= '0;
                r_row     <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Read-side counter and bank select; full flags updated together.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            r_rd_cnt  <= '0;
            r_rd_bank <= 1'b0;
            r_full    <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
            if (w_rd_last) begin
                r_rd_cnt  <= '0;
                r_rd_bank <= ~r_rd_bank;
            end else if (w_rd_fire) begin
                r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
            end
        end
    end

`ifdef DEINTERLEAVER_LAST_EN
    logic [15:0] r_blk_cnt;

    // Count blocks fully delivered downstream (wraps at 16 bits).
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            r_blk_cnt <= '0;
        end else if (w_rd_last) begin
            r_blk_cnt <= r_blk_cnt + 16'd1;
        end
    end

    assign bus.last_deinterleaver = w_valid & (r_rd_cnt == ADDR_W'(NCBPS - 1));
    assign bus.block_count        = r_blk_cnt;
`endif
endmodule

// File: tb/tb_deinterleaver.sv
// tb_deinterleaver: directed self-checking bench for the deinterleaver.
// Golden block, streaming, index map, backpressure, mid-block reset and optional last/count outputs.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_deinterleaver;
    logic clk;
    logic resetN;

    deinterleaver_if #(.NCBPS(192)) bus ();

    deinterleaver #(.NCBPS(192), .NCPC(2), .D(16)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [191:0] gold_in  = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;
    logic [191:0] gold_out = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.valid_demapper = 1'b0;
        bus.data_in        = 1'b0;
        bus.ready_decoder  = 1'b0;
        resetN = 1'b1;
        tick();
        tick();
        resetN = 1'b0;
        tick();
    endtask

    // Stream one block MSB-first, waiting (bounded) on ready; returns the number of stall cycles.
    task automatic feed_block(input logic [191:0] blk, output int stalls);
        int guard;
        stalls = 0;
        for (int j = 0; j < 192; j++) begin
            bus.valid_demapper = 1'b1;
            bus.data_in        = blk[191-j];
            guard = 0;
            while (!bus.ready_deinterleaver && guard < 3000) begin
                tick();
                guard++;
                stalls++;
            end
            tick();
        end
        bus.valid_demapper = 1'b0;
        bus.data_in        = 1'b0;
    endtask

    // Collect one output block MSB-first with ready_decoder high; counts idle cycles and index errors.
    task automatic collect_block(output logic [191:0] blk, output int idx_bad, output int idle);
        int budget;
        blk     = '0;
        idx_bad = 0;
        idle    = 0;
        budget  = 3000;
        bus.ready_decoder = 1'b1;
        for (int i = 0; i < 192; i++) begin
            while (!bus.valid_deinterleaver && budget > 0) begin
                tick();
                idle++;
                budget--;
            end
            blk[191-i] = bus.data_out;
            if (bus.data_out_index !== 8'(i)) idx_bad++;
            tick();
        end
    endtask

    task automatic test_reset();
        bus.valid_demapper = 1'b0;
        bus.data_in        = 1'b0;
        bus.ready_decoder  = 1'b0;
        resetN = 1'b1;
        tick();
        total++;
        if (bus.ready_deinterleaver !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b want=1", bus.ready_deinterleaver);
        end
        total++;
        if (bus.valid_deinterleaver !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b want=0", bus.valid_deinterleaver);
        end
        total++;
        if (bus.data_out !== 1'b0) begin
            bad++; $display("FAIL reset_data got=%b want=0", bus.data_out);
        end
        total++;
        if (bus.data_out_index !== 8'd0) begin
            bad++; $display("FAIL reset_index got=%0d want=0", bus.data_out_index);
        end
`ifdef DEINTERLEAVER_LAST_EN
        total++;
        if (bus.last_deinterleaver !== 1'b0) begin
            bad++; $display("FAIL reset_last got=%b want=0", bus.last_deinterleaver);
        end
        total++;
        if (bus.block_count !== 16'd0) begin
            bad++; $display("FAIL reset_block_count got=%0d want=0", bus.block_count);
        end
`endif
        resetN = 1'b0;
        tick();
    endtask

    task automatic test_golden();
        logic [191:0] blk;
        int idx_bad, idle;
        do_reset();
        bus.ready_decoder = 1'b1;
        for (int j = 0; j < 192; j++) begin
            bus.valid_demapper = 1'b1;
            bus.data_in        = gold_in[191-j];
            if (j == 191) begin
                total++;
                if (bus.valid_deinterleaver !== 1'b0) begin
                    bad++; $display("FAIL golden_early_valid got=%b want=0", bus.valid_deinterleaver);
                end
            end
            tick();
        end
        bus.valid_demapper = 1'b0;
        total++;
        if (bus.valid_deinterleaver !== 1'b1) begin
            bad++; $display("FAIL golden_latency got_valid=%b want=1", bus.valid_deinterleaver);
        end
        collect_block(blk, idx_bad, idle);
        total++;
        if (blk !== gold_out) begin
            bad++; $display("FAIL golden_data got=%h want=%h", blk, gold_out);
        end
        total++;
        if (idx_bad !== 0) begin
            bad++; $display("FAIL golden_index_order bad_indices=%0d want=0", idx_bad);
        end
        total++;
        if (idle !== 0) begin
            bad++; $display("FAIL golden_idle got=%0d want=0", idle);
        end
    endtask

    task automatic test_streaming();
        int stall_sum;
        int idle_sum;
        int data_bad;
        int idx_sum;
        do_reset();
        stall_sum = 0;
        idle_sum  = 0;
        data_bad  = 0;
        idx_sum   = 0;
        fork
            begin
                int st;
                for (int b = 0; b < 10; b++) begin
                    feed_block(gold_in, st);
                    stall_sum += st;
                end
            end
            begin
                logic [191:0] blk;
                int ib, idl;
                for (int b = 0; b < 10; b++) begin
                    collect_block(blk, ib, idl);
                    if (blk !== gold_out) data_bad++;
                    idx_sum += ib;
                    if (b > 0) idle_sum += idl;
                end
            end
        join
        total++;
        if (stall_sum !== 0) begin
            bad++; $display("FAIL stream_ready_stalls got=%0d want=0", stall_sum);
        end
        total++;
        if (data_bad !== 0) begin
            bad++; $display("FAIL stream_data bad_blocks=%0d want=0", data_bad);
        end
        total++;
        if (idx_sum !== 0) begin
            bad++; $display("FAIL stream_index bad_indices=%0d want=0", idx_sum);
        end
        total++;
        if (idle_sum !== 0) begin
            bad++; $display("FAIL stream_idle got=%0d want=0", idle_sum);
        end
    endtask

    task automatic test_index_map();
        int j_tab [3] = '{1, 12, 191};
        int k_tab [3] = '{16, 1, 191};
        logic [191:0] stim, expv, blk;
        int idx_bad, idle, st;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            stim = '0;
            stim[191 - j_tab[t]] = 1'b1;
            expv = '0;
            expv[191 - k_tab[t]] = 1'b1;
            bus.ready_decoder = 1'b1;
            feed_block(stim, st);
            collect_block(blk, idx_bad, idle);
            total++;
            if (blk !== expv) begin
                bad++; $display("FAIL index_map_j%0d got=%h want=%h", j_tab[t], blk, expv);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [191:0] b0, b1, b2;
        logic [191:0] inv_in, inv_out;
        logic exp_bit;
        int st, hold_bad, ib0, ib1, ib2, idl;
        do_reset();
        inv_in  = ~gold_in;
        inv_out = ~gold_out;
        exp_bit = inv_out[191];
        bus.ready_decoder = 1'b0;
        feed_block(inv_in, st);
        feed_block(gold_in, st);
        total++;
        if (bus.ready_deinterleaver !== 1'b0) begin
            bad++; $display("FAIL bp_ready_after_384 got=%b want=0", bus.ready_deinterleaver);
        end
        total++;
        if (bus.valid_deinterleaver !== 1'b1) begin
            bad++; $display("FAIL bp_valid got=%b want=1", bus.valid_deinterleaver);
        end
        total++;
        if (bus.data_out_index !== 8'd0) begin
            bad++; $display("FAIL bp_index got=%0d want=0", bus.data_out_index);
        end
        hold_bad = 0;
        fork
            feed_block(gold_in, st);
            begin
                for (int c = 0; c < 10; c++) begin
                    tick();
                    if (bus.data_out_index !== 8'd0 || bus.data_out !== exp_bit ||
                        bus.valid_deinterleaver !== 1'b1 || bus.ready_deinterleaver !== 1'b0)
                        hold_bad++;
                end
                collect_block(b0, ib0, idl);
                collect_block(b1, ib1, idl);
                collect_block(b2, ib2, idl);
            end
        join
        total++;
        if (hold_bad !== 0) begin
            bad++; $display("FAIL bp_hold unstable_cycles=%0d want=0", hold_bad);
        end
        total++;
        if (b0 !== inv_out) begin
            bad++; $display("FAIL bp_block0 got=%h want=%h", b0, inv_out);
        end
        total++;
        if (b1 !== gold_out) begin
            bad++; $display("FAIL bp_block1 got=%h want=%h", b1, gold_out);
        end
        total++;
        if (b2 !== gold_out) begin
            bad++; $display("FAIL bp_stalled_block got=%h want=%h", b2, gold_out);
        end
        total++;
        if ((ib0 + ib1 + ib2) !== 0) begin
            bad++; $display("FAIL bp_index_order bad_indices=%0d want=0", ib0 + ib1 + ib2);
        end
    endtask

    task automatic test_reset_mid_block();
        logic [191:0] inv_in, blk;
        int st, idx_bad, idle;
        do_reset();
        inv_in = ~gold_in;
        bus.ready_decoder = 1'b1;
        for (int j = 0; j < 100; j++) begin
            bus.valid_demapper = 1'b1;
            bus.data_in        = inv_in[191-j];
            tick();
        end
        bus.valid_demapper = 1'b0;
        resetN = 1'b1;
        #1;
        total++;
        if (bus.valid_deinterleaver !== 1'b0) begin
            bad++; $display("FAIL midreset_valid got=%b want=0", bus.valid_deinterleaver);
        end
        total++;
        if (bus.ready_deinterleaver !== 1'b1) begin
            bad++; $display("FAIL midreset_ready got=%b want=1", bus.ready_deinterleaver);
        end
        tick();
        resetN = 1'b0;
        tick();
        feed_block(gold_in, st);
        collect_block(blk, idx_bad, idle);
        total++;
        if (blk !== gold_out) begin
            bad++; $display("FAIL midreset_block got=%h want=%h", blk, gold_out);
        end
    endtask

`ifdef DEINTERLEAVER_LAST_EN
    task automatic test_last();
        int pulses, wrong;
        do_reset();
        pulses = 0;
        wrong  = 0;
        bus.ready_decoder = 1'b1;
        fork
            begin
                int st;
                for (int b = 0; b < 10; b++) feed_block(gold_in, st);
            end
            begin
                for (int c = 0; c < 2200; c++) begin
                    if (bus.last_deinterleaver === 1'b1) begin
                        pulses++;
                        if (bus.data_out_index !== 8'd191 || bus.valid_deinterleaver !== 1'b1) wrong++;
                    end
                    tick();
                end
            end
        join
        total++;
        if (pulses !== 10) begin
            bad++; $display("FAIL last_pulses got=%0d want=10", pulses);
        end
        total++;
        if (wrong !== 0) begin
            bad++; $display("FAIL last_position got=%0d want=0", wrong);
        end
        total++;
        if (bus.block_count !== 16'd10) begin
            bad++; $display("FAIL block_count got=%0d want=10", bus.block_count);
        end
    endtask
`endif

    initial begin
        resetN             = 1'b1;
        bus.valid_demapper = 1'b0;
        bus.data_in        = 1'b0;
        bus.ready_decoder  = 1'b0;
        test_reset();
        test_golden();
        test_streaming();
        test_index_map();
        test_backpressure();
        test_reset_mid_block();
`ifdef DEINTERLEAVER_LAST_EN
        test_last();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
